// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs, FSM states,
// ALU and mux selector codes. Imported by the controller and its benches.
package mips_defs;

    typedef enum logic [2:0] {
        StIfetch = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    localparam logic [5:0] OpcRtype = 6'h00;
    localparam logic [5:0] OpcAddi  = 6'h08;
    localparam logic [5:0] OpcLui   = 6'h0F;
    localparam logic [5:0] OpcLw    = 6'h23;
    localparam logic [5:0] OpcSw    = 6'h2B;
    localparam logic [5:0] OpcBeq   = 6'h04;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluAnd   = 4'd2;
    localparam logic [3:0] AluOr    = 4'd3;
    localparam logic [3:0] AluSlt   = 4'd4;
    localparam logic [3:0] AluPassB = 4'd15;

    localparam logic [1:0] SrcReg  = 2'd0;
    localparam logic [1:0] SrcFour = 2'd1;
    localparam logic [1:0] SrcImm  = 2'd2;

    localparam logic [1:0] WbAlu = 2'd0;
    localparam logic [1:0] WbMem = 2'd1;
    localparam logic [1:0] WbLui = 2'd2;

    function automatic logic opcode_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OpcRtype, OpcAddi, OpcLui, OpcLw, OpcSw, OpcBeq: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Returns {valid, alu_op} for an R-type funct field.
    function automatic logic [4:0] rtype_alu_op(input logic [5:0] fn);
        logic [4:0] res;
        case (fn)
            FnAdd:   res = {1'b1, AluAdd};
            FnSub:   res = {1'b1, AluSub};
            FnAnd:   res = {1'b1, AluAnd};
            FnOr:    res = {1'b1, AluOr};
            FnSlt:   res = {1'b1, AluSlt};
            default: res = {1'b0, AluAdd};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mcycle_control.sv
// Multicycle MIPS control FSM: IFETCH/DECODE/EXEC/MEM/WB sequencing with unbounded memory
// waits, a sticky illegal-instruction flag, and state exported for debug.
module mcycle_control
    import mips_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] wb_sel,
    output logic       pc_sel,
    output logic       illegal,
    output logic [2:0] state
);

    state_e     state_q, state_d;
    logic [5:0] op_q, funct_q;
    logic       illegal_q, illegal_d;
    logic [4:0] r_dec;

    assign r_dec   = rtype_alu_op(funct_q);
    assign state   = state_q;
    assign illegal = illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIfetch;
            op_q      <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (state_q == StDecode) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
        end
    end

    always_comb begin
        state_d   = StIfetch;
        illegal_d = illegal_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        alu_op    = AluAdd;
        alu_src_b = SrcReg;
        wb_sel    = WbAlu;
        pc_sel    = 1'b0;

        unique case (state_q)
            StIfetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcFour;
                // Reset parks the FSM here; keep the write pulses quiet while it is held.
                if (mem_ready && !reset) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else begin
                    state_d  = StIfetch;
                end
            end

            StDecode: begin
                if (opcode_supported(opcode)) begin
                    state_d = StExec;
                end else begin
                    state_d   = StIfetch;
                    illegal_d = 1'b1;
                end
            end

            StExec: begin
                case (op_q)
                    OpcRtype: begin
                        if (r_dec[4]) begin
                            alu_op  = r_dec[3:0];
                            state_d = StWb;
                        end else begin
                            illegal_d = 1'b1;
                            state_d   = StIfetch;
                        end
                    end
                    OpcAddi: begin
                        alu_src_b = SrcImm;
                        state_d   = StWb;
                    end
                    OpcLw, OpcSw: begin
                        alu_src_b = SrcImm;
                        state_d   = StMem;
                    end
                    OpcLui: begin
                        alu_op  = AluPassB;
                        state_d = StWb;
                    end
                    OpcBeq: begin
                        alu_op   = AluSub;
                        pc_write = zero;
                        pc_sel   = zero;
                        state_d  = StIfetch;
                    end
                    default: state_d = StIfetch;
                endcase
            end

            StMem: begin
                mem_read  = (op_q == OpcLw);
                mem_write = (op_q != OpcLw);
                if (mem_ready) begin
                    state_d = (op_q == OpcLw) ? StWb : StIfetch;
                end else begin
                    state_d = StMem;
                end
            end

            StWb: begin
                reg_write = 1'b1;
                if (op_q == OpcLw) begin
                    wb_sel = WbMem;
                end else if (op_q == OpcLui) begin
                    wb_sel = WbLui;
                end else begin
                    wb_sel = WbAlu;
                end
                state_d = StIfetch;
            end

            default: state_d = StIfetch;
        endcase
    end

endmodule
